// File: rtl/seg7_irrigacao_decoder_if.sv
// Handshake bundle carrying decoded irrigation events.
// master: code/out_valid out, out_ready in; slave: reverse.
interface seg7_irrigacao_decoder_if;
  logic [1:0] code;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output code,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  code,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/seg7_irrigacao_decoder.sv
// Irrigation 7-seg receiver: debounces A..G, decodes the 2-bit code,
// emits one event per accepted change over bus (code/out_valid/out_ready).
// Ports: clk, reset (sync, active-high), A..G segment lines, bus (master),
// err pulse, err_cnt saturating illegal count, ovf sticky drop flag.
// SEG_ACTIVE_LOW_EN: treat A..G as active-low (common-anode display).
module seg7_irrigacao_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             D,
  input  logic             E,
  input  logic             F,
  input  logic             G,
  seg7_irrigacao_decoder_if.master bus,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             ovf
);

  typedef enum logic {
    SETTLE,
    LOCKED
  } state_t;

  localparam logic [3:0] STABLE =
    4'(STABLE_CYCLES);
  localparam logic [ERR_W-1:0] ONE =
    {{(ERR_W-1){1'b0}}, 1'b1};

  state_t     state;
  logic [6:0] word;
  logic [6:0] seg_q;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic [6:0] last_acc;
  logic       last_vld;
  logic       legal;
  logic [1:0] dec;
  logic       free;
  logic       fresh;

`ifdef SEG_ACTIVE_LOW_EN
  assign word = ~{A, B, C, D, E, F, G};
`else
  assign word = {A, B, C, D, E, F, G};
`endif

  always_comb begin
    legal = 1'b1;
    dec   = 2'b00;
    unique case (1'b1)
      (word == 7'b0000000): dec = 2'b00;
      (word == 7'b1111110): dec = 2'b01;
      (word == 7'b0110000): dec = 2'b10;
      (word == 7'b1101101): dec = 2'b11;
      default:              legal = 1'b0;
    endcase
  end

  assign cnt_nxt = cnt + 4'd1;
  // Room for a new event if empty or draining this edge.
  assign free = !bus.out_valid || bus.out_ready;
  // last_vld=0 is the NONE sentinel: nothing matches it.
  assign fresh = !last_vld || (word != last_acc);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= SETTLE;
      seg_q         <= 7'b0;
      cnt           <= 4'd0;
      last_acc      <= 7'b0;
      last_vld      <= 1'b0;
      bus.code      <= 2'b00;
      bus.out_valid <= 1'b0;
      err           <= 1'b0;
      err_cnt       <= '0;
      ovf           <= 1'b0;
    end else begin
      err <= 1'b0;
      if (bus.out_valid && bus.out_ready)
        bus.out_valid <= 1'b0;
      if (word != seg_q) begin
        seg_q <= word;
        cnt   <= 4'd0;
        state <= SETTLE;
      end else if (state == SETTLE) begin
        cnt <= cnt_nxt;
        if (cnt_nxt == STABLE) begin
          state <= LOCKED;
          if (fresh) begin
            last_acc <= word;
            last_vld <= 1'b1;
            if (legal) begin
              if (free) begin
                bus.code      <= dec;
                bus.out_valid <= 1'b1;
              end else begin
                ovf <= 1'b1;
              end
            end else begin
              err <= 1'b1;
              if (err_cnt != '1)
                err_cnt <= err_cnt + ONE;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_irrigacao_decoder.sv
// Randomized + directed bench for seg7_irrigacao_decoder.
// Outputs are compared every cycle against a run-length reference model.
module tb_seg7_irrigacao_decoder;

  localparam int S     = 4;
  localparam int ERR_W = 4;
  localparam int EMAX  = (1 << ERR_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic A, B, C, D, E, F, G;
  logic err;
  logic [ERR_W-1:0] err_cnt;
  logic ovf;

  seg7_irrigacao_decoder_if bus ();

  seg7_irrigacao_decoder #(
    .STABLE_CYCLES(S),
    .ERR_W(ERR_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .A(A), .B(B), .C(C), .D(D),
    .E(E), .F(F), .G(G),
    .bus(bus),
    .err(err),
    .err_cnt(err_cnt),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference model: a word is accepted when it has been seen
  // on exactly S+1 consecutive samples (reset counts as one 0).
  logic [6:0] legal_tab [4] = '{
    7'b0000000, 7'b1111110,
    7'b0110000, 7'b1101101
  };

  logic [6:0] m_prev;
  int         m_run;
  bit         m_has_last;
  logic [6:0] m_last;
  bit         m_valid;
  int         m_code;
  bit         m_err;
  int         m_ecnt;
  bit         m_ovf;

  function automatic int lookup(input logic [6:0] w);
    for (int i = 0; i < 4; i++)
      if (legal_tab[i] == w) return i;
    return -1;
  endfunction

  task automatic model_step(
    input logic [6:0] w,
    input logic r,
    input logic rs
  );
    bit free;
    int k;
    if (rs) begin
      m_prev = '0; m_run = 1;
      m_has_last = 0; m_last = '0;
      m_valid = 0; m_code = 0;
      m_err = 0; m_ecnt = 0; m_ovf = 0;
      return;
    end
    free = !m_valid || r;
    if (m_valid && r) m_valid = 0;
    m_err = 0;
    if (w == m_prev) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_prev = w;
      m_run = 1;
    end
    if (m_run == S + 1) begin
      if (!m_has_last || w != m_last) begin
        m_has_last = 1;
        m_last = w;
        k = lookup(w);
        if (k < 0) begin
          m_err = 1;
          if (m_ecnt < EMAX) m_ecnt++;
        end else if (free) begin
          m_valid = 1;
          m_code = k;
        end else begin
          m_ovf = 1;
        end
      end
    end
  endtask

  task automatic cyc(
    input logic [6:0] w,
    input logic r,
    input logic rs
  );
`ifdef SEG_ACTIVE_LOW_EN
    {A, B, C, D, E, F, G} = ~w;
`else
    {A, B, C, D, E, F, G} = w;
`endif
    bus.out_ready = r;
    reset = rs;
    @(posedge clk);
    model_step(w, r, rs);
    #1;
    chk("valid", 32'(bus.out_valid), 32'(m_valid));
    if (m_valid)
      chk("code", 32'(bus.code), 32'(m_code));
    chk("err", 32'(err), 32'(m_err));
    chk("err_cnt", 32'(err_cnt), 32'(m_ecnt));
    chk("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic hold(
    input logic [6:0] w,
    input logic r,
    input int n
  );
    for (int i = 0; i < n; i++) cyc(w, r, 1'b0);
  endtask

  int evt;
  logic [6:0] w;

  initial begin
    cyc(7'b0, 1'b1, 1'b1);
    cyc(7'b0, 1'b1, 1'b1);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_code", 32'(bus.code), 0);
    chk("rst_ecnt", 32'(err_cnt), 0);

    // Blank after reset: event on edge 4 only.
    hold(7'b0, 1'b1, 3);
    chk("blank_early", 32'(bus.out_valid), 0);
    cyc(7'b0, 1'b1, 1'b0);
    chk("blank_evt", 32'(bus.out_valid), 1);
    chk("blank_code", 32'(bus.code), 0);
    hold(7'b0, 1'b1, 3);

    // Single event for a long hold.
    evt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(7'b1111110, 1'b1, 1'b0);
      if (bus.out_valid) evt++;
    end
    chk("one_evt", 32'(evt), 1);

    // Glitch and return are suppressed.
    hold(7'b0110000, 1'b1, 8);
    evt = 0;
    for (int i = 0; i < 2; i++) begin
      cyc(7'b1101101, 1'b1, 1'b0);
      if (bus.out_valid) evt++;
    end
    for (int i = 0; i < 8; i++) begin
      cyc(7'b0110000, 1'b1, 1'b0);
      if (bus.out_valid) evt++;
    end
    chk("glitch_evt", 32'(evt), 0);

    // Backpressure: hold first, drop second.
    hold(7'b0, 1'b1, 8);
    hold(7'b0110000, 1'b0, 6);
    hold(7'b1101101, 1'b0, 6);
    chk("bp_ovf", 32'(ovf), 1);
    chk("bp_code", 32'(bus.code), 2);
    cyc(7'b1101101, 1'b1, 1'b0);
    chk("bp_drain", 32'(bus.out_valid), 0);

    // Illegal pattern saturation.
    for (int i = 0; i < 20; i++) begin
      hold(7'b1010101, 1'b1, 6);
      hold(7'b0000000, 1'b1, 6);
    end
    chk("sat", 32'(err_cnt), EMAX);

    // Reset mid-settle.
    hold(7'b1111110, 1'b1, 2);
    cyc(7'b1111110, 1'b1, 1'b1);
    chk("mid_rst_ovf", 32'(ovf), 0);
    chk("mid_rst_ecnt", 32'(err_cnt), 0);

    // Random segments, hold lengths and backpressure.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(3) != 0)
        w = legal_tab[$urandom_range(3)];
      else
        w = 7'($urandom);
      for (int i = $urandom_range(8, 1); i > 0; i--)
        cyc(w, 1'($urandom_range(2) != 0),
            1'($urandom_range(199) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
